instr_sequencer: RTL and testbench

- Fetch/decode/sequencing stage directly upstream of the 4-bit computational unit.
- Holds the program counter, fetches 8-bit instructions from program memory, and registers them into ir.
- Decodes ir into the computational unit's control set: source_sel, reg_en, i_sel, x_sel, y_sel, nibble_ir, sync_reset.
- Executes unconditional and conditional jumps using the unit's r_eq_0 flag, and supports halt.

---
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/sequencing stage for the 4-bit computational unit: PC, IR, jumps, halt.
// Optional SINGLE_STEP_EN macro adds a step_en input that gates advancement in RUN.
module instr_sequencer #(
  parameter int PC_W         = 8,
  parameter int RESET_VECTOR = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
`ifdef SINGLE_STEP_EN
  input  logic            step_en,
`endif
  output logic [PC_W-1:0] pm_addr,
  output logic [7:0]      ir,
  output logic [3:0]      nibble_ir,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic            sync_reset,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [7:0] IR_NOP  = 8'hFE;
  localparam logic [7:0] IR_HALT = 8'hFF;
  localparam logic [7:0] IR_JMP  = 8'hE0;
  localparam logic [7:0] IR_JNZ  = 8'hE1;
  localparam logic [7:0] IR_JZ   = 8'hE2;
  localparam logic [2:0] REG_I   = 3'd6;
  localparam logic [2:0] REG_DM  = 3'd7;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic            r_sync_reset;
  logic            r_halted;

  logic            w_advance;
  logic            w_is_jump;
  logic            w_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;
  logic [8:0]      w_reg_en;
  logic [2:0]      w_dst;
  logic            w_dst_valid;
  logic            w_dm_access;

`ifdef SINGLE_STEP_EN
  assign w_advance = step_en;
`else
  assign w_advance = 1'b1;
`endif

  assign w_is_jump = (r_ir == IR_JMP) || (r_ir == IR_JNZ) || (r_ir == IR_JZ);
  assign w_taken   = (r_ir == IR_JMP) || ((r_ir == IR_JNZ) && !r_eq_0) ||
                     ((r_ir == IR_JZ) && r_eq_0);
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_target  = PC_W'(pm_data);

  // Register code -> write-enable bit; o_reg (code 4) lives at bit 8.
  function automatic logic [8:0] dst_enable(input logic [2:0] code);
    logic [8:0] en;
    en = '0;
    case (code)
      3'd4:    en[8] = 1'b1;
      default: en[code] = 1'b1;
    endcase
    return en;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RST_HOLD;
      r_pc         <= PC_W'(RESET_VECTOR);
      r_ir         <= IR_NOP;
      r_sync_reset <= 1'b1;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_HOLD: begin
          r_ir         <= pm_data;
          r_pc         <= w_pc_inc;
          r_sync_reset <= 1'b0;
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          if (w_advance) begin
            if (r_ir == IR_HALT) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (w_is_jump) begin
              // pm_data is the operand byte here; the bubble replaces it in ir.
              r_pc <= w_taken ? w_target : w_pc_inc;
              r_ir <= IR_NOP;
            end else begin
              r_ir <= pm_data;
              r_pc <= w_pc_inc;
            end
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_RST_HOLD;
        end
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_reg_en    = '0;
    source_sel  = 4'hA;
    i_sel       = 1'b0;
    x_sel       = 1'b0;
    y_sel       = 1'b0;
    w_dst       = '0;
    w_dst_valid = 1'b0;
    w_dm_access = 1'b0;
    if (!r_ir[7]) begin
      source_sel  = 4'h8;
      w_dst       = r_ir[6:4];
      w_dst_valid = 1'b1;
    end else if (r_ir[7:6] == 2'b10) begin
      source_sel  = {1'b0, r_ir[2:0]};
      w_dst       = r_ir[5:3];
      w_dst_valid = 1'b1;
      w_dm_access = (r_ir[2:0] == REG_DM);
    end else if (r_ir[7:5] == 3'b110) begin
      w_reg_en[4] = 1'b1;
      x_sel       = r_ir[4];
      y_sel       = r_ir[3];
    end
    if (w_dst_valid) begin
      w_reg_en = w_reg_en | dst_enable(w_dst);
      if (w_dst == REG_DM) w_dm_access = 1'b1;
    end
    // dm access post-increments i, unless i is itself the destination.
    if (w_dm_access) begin
      w_reg_en[6] = 1'b1;
      i_sel       = !(w_dst_valid && (w_dst == REG_I));
    end
  end

  assign reg_en     = ((r_state == ST_RUN) && w_advance) ? w_reg_en : '0;
  assign pm_addr    = r_pc;
  assign ir         = r_ir;
  assign nibble_ir  = r_ir[3:0];
  assign sync_reset = r_sync_reset;
  assign halted     = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed programs plus randomized program
// memory, checked each cycle against a behavioural model of the fetch/jump/halt rules.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic       step_en;
  logic [7:0] pm_addr;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel, x_sel, y_sel, sync_reset, halted;

  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  // Model state: program counter, instruction register, hold/halt phases.
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  bit         m_hold;
  bit         m_halted;

  // Register code 0..7 (x0,x1,y0,y1,o_reg,m,i,dm) -> reg_en bit.
  localparam int DST_BIT [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

  assign pm_data = mem[pm_addr];

  instr_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
`ifdef SINGLE_STEP_EN
    .step_en    (step_en),
`endif
    .pm_addr    (pm_addr),
    .ir         (ir),
    .nibble_ir  (nibble_ir),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .i_sel      (i_sel),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .sync_reset (sync_reset),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void exp_decode(input logic [7:0] ir_v, input bit active,
                                     output logic [8:0] en, output logic [3:0] src,
                                     output logic isel, output logic xs, output logic ys);
    int dst  = -1;
    int srcc = -1;
    en = '0; src = 4'hA; isel = 1'b0; xs = 1'b0; ys = 1'b0;
    if (ir_v < 8'h80) begin
      dst = int'(ir_v[6:4]);
      src = 4'h8;
    end else if (ir_v < 8'hC0) begin
      dst  = int'(ir_v[5:3]);
      srcc = int'(ir_v[2:0]);
      src  = 4'(srcc);
    end else if (ir_v < 8'hE0) begin
      en[4] = 1'b1;
      xs    = ir_v[4];
      ys    = ir_v[3];
    end
    if (dst >= 0) en[DST_BIT[dst]] = 1'b1;
    if (dst == 7 || srcc == 7) begin
      en[6] = 1'b1;
      isel  = (dst != 6);
    end
    if (!active) en = '0;
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'hFE; m_hold = 1'b1; m_halted = 1'b0;
  endtask

  task automatic model_edge();
    bit taken;
    if (m_hold) begin
      m_ir = mem[m_pc]; m_pc = m_pc + 8'd1; m_hold = 1'b0;
    end else if (m_halted || !step_en) begin
      // frozen
    end else if (m_ir == 8'hFF) begin
      m_halted = 1'b1;
    end else if (m_ir == 8'hE0 || m_ir == 8'hE1 || m_ir == 8'hE2) begin
      taken = (m_ir == 8'hE0) || (m_ir == 8'hE1 && !r_eq_0) || (m_ir == 8'hE2 && r_eq_0);
      m_pc  = taken ? mem[m_pc] : m_pc + 8'd1;
      m_ir  = 8'hFE;
    end else begin
      m_ir = mem[m_pc]; m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic compare_all();
    logic [8:0] e_en;
    logic [3:0] e_src;
    logic       e_isel, e_x, e_y;
    exp_decode(m_ir, !m_hold && !m_halted && step_en, e_en, e_src, e_isel, e_x, e_y);
    check("pm_addr",    32'(pm_addr),    32'(m_pc));
    check("ir",         32'(ir),         32'(m_ir));
    check("nibble_ir",  32'(nibble_ir),  32'(m_ir[3:0]));
    check("reg_en",     32'(reg_en),     32'(e_en));
    check("source_sel", 32'(source_sel), 32'(e_src));
    check("i_sel",      32'(i_sel),      32'(e_isel));
    check("x_sel",      32'(x_sel),      32'(e_x));
    check("y_sel",      32'(y_sel),      32'(e_y));
    check("sync_reset", 32'(sync_reset), 32'(m_hold));
    check("halted",     32'(halted),     32'(m_halted));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic run_cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Called on a falling edge: asynchronous assert, hold across an edge, release.
  task automatic apply_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    #1 compare_all();
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  initial begin
    reset_n = 1'b0;
    r_eq_0  = 1'b0;
    step_en = 1'b1;
    model_reset();

    // Directed program: load, moves with dm, ALU, JNZ taken, JMP, JZ not taken, HALT.
    fill_mem(8'hFE);
    mem[8'h00] = 8'h25; mem[8'h01] = 8'h87; mem[8'h02] = 8'hB7; mem[8'h03] = 8'hD2;
    mem[8'h04] = 8'hE1; mem[8'h05] = 8'h40;
    mem[8'h40] = 8'hE0; mem[8'h41] = 8'h10;
    mem[8'h10] = 8'hE2; mem[8'h11] = 8'h33; mem[8'h12] = 8'hFF;
    @(negedge clk);
    apply_reset();
    check("rel_sync_reset", 32'(sync_reset), 32'd1);
    check("rel_pm_addr",    32'(pm_addr),    32'd0);
    run_cycle();
    check("e1_ir",         32'(ir),         32'h25);
    check("e1_reg_en",     32'(reg_en),     32'h004);
    check("e1_source_sel", 32'(source_sel), 32'd8);
    check("e1_nibble",     32'(nibble_ir),  32'd5);
    check("e1_pm_addr",    32'(pm_addr),    32'd1);
    check("e1_sync_reset", 32'(sync_reset), 32'd0);
    run_cycle();
`ifdef SINGLE_STEP_EN
    step_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      check("step_pm_addr", 32'(pm_addr), 32'd2);
      check("step_ir",      32'(ir),      32'h87);
      check("step_reg_en",  32'(reg_en),  32'd0);
    end
    step_en = 1'b1;
    #1;
`endif
    check("mv_dm_source", 32'(source_sel), 32'd7);
    check("mv_dm_reg_en", 32'(reg_en),     32'h041);
    check("mv_dm_i_sel",  32'(i_sel),      32'd1);
    run_cycle();
    check("mv_i_reg_en",  32'(reg_en),     32'h040);
    check("mv_i_i_sel",   32'(i_sel),      32'd0);
    run_cycle();
    check("alu_reg_en",   32'(reg_en),     32'h010);
    check("alu_x_sel",    32'(x_sel),      32'd1);
    check("alu_y_sel",    32'(y_sel),      32'd0);
    run_cycle();
    run_cycle();
    check("jnz_pm_addr",  32'(pm_addr),    32'h40);
    check("jnz_bubble",   32'(ir),         32'hFE);
    repeat (4) run_cycle();
    check("jz_pm_addr",   32'(pm_addr),    32'h12);
    check("jz_bubble",    32'(ir),         32'hFE);
    run_cycle();
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      check("halt_halted",  32'(halted),  32'd1);
      check("halt_pm_addr", 32'(pm_addr), 32'h13);
      check("halt_reg_en",  32'(reg_en),  32'd0);
    end
    #2 reset_n = 1'b0;
    #1 model_reset();
    check("rst_in_halt_pm_addr", 32'(pm_addr), 32'd0);
    check("rst_in_halt_halted",  32'(halted),  32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Jump whose operand wraps from address FF to 0.
    fill_mem(8'hFE);
    mem[8'h00] = 8'hE0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'hE0; mem[8'hE0] = 8'hFF;
    apply_reset();
    repeat (3) run_cycle();
    check("wrap_pm_addr", 32'(pm_addr), 32'h00);
    run_cycle();
    check("wrap_target",  32'(pm_addr), 32'hE0);
    repeat (3) run_cycle();
    check("wrap_halted",  32'(halted),  32'd1);

    // Randomized programs, flag, step gating and asynchronous resets.
    for (int run = 0; run < 24; run++) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom_range(255));
      apply_reset();
      for (int c = 0; c < 200; c++) begin
        r_eq_0 = 1'($urandom_range(1));
`ifdef SINGLE_STEP_EN
        step_en = ($urandom_range(3) != 0);
`endif
        run_cycle();
        if ($urandom_range(99) == 0) apply_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
